pkt_store_fwd: RTL and testbench

- Store-and-forward packet buffer for the 134-bit packet bus, placed between the RGMII/GMII runtime output and the user-module input.
- Accepts a valid-only input stream with no backpressure and buffers only complete, well-formed packets.
- Emits each buffered packet as a contiguous burst, so the consumer never sees partial or gapped packets.
- Drops packets that overflow the buffer or are malformed, and counts them.

---
 rtl/pkt_store_fwd.sv | 218 +++++++++++++++++++++
 tb/tb_pkt_store_fwd.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_store_fwd.sv
// ---------------------------------------------------------------------------
// pkt_store_fwd
//
// Store-and-forward buffer for the 134-bit packet bus. This sits between the
// RGMII/GMII receive path and the user-module input. The input is a
// valid-only stream with no backpressure. A packet becomes visible to the
// read side only after its tail has been written, so the consumer always
// receives a whole packet as one gap-free burst. Packets that overflow the
// buffer, and packets cut short by a new head, are rewound out of the buffer
// and counted as drops.
//
// Beat format: [133:132] tag (01 head, 00 body, 10/11 tail),
//              [131:128] valid-byte tag, [127:0] data.
//
// Ports
//   clk             packet clock (125 MHz)
//   rst_n           asynchronous active-low reset
//   data_in_valid   input beat valid
//   data_in         input beat
//   data_out_valid  output beat valid
//   data_out        output beat; forced to 0 when data_out_valid is low
//   pkt_in_cnt      packets committed to the buffer (wraps at 2^32)
//   pkt_drop_cnt    packets aborted or dropped (wraps at 2^32)
//   buf_used        beats occupied, wr_ptr - rd_ptr
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for a head beat; non-head beats are ignored
//   W_PKT  | storing the body of a packet until its tail
//   W_DROP | discarding the rest of a dropped packet until its tail
//
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for a committed packet
//   R_SEND | issuing one RAM read per cycle until the tail beat is read
// ---------------------------------------------------------------------------
module pkt_store_fwd #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_in_valid,
  input  logic [133:0]      data_in,
  output logic              data_out_valid,
  output logic [133:0]      data_out,
  output logic [31:0]       pkt_in_cnt,
  output logic [31:0]       pkt_drop_cnt,
  output logic [ADDR_W:0]   buf_used
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_PKT  = 2'd1;
  localparam logic [1:0] W_DROP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_SEND = 1'b1;

  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  // Storage. tail_flag mirrors bit 133 of each stored beat so the read side
  // knows at issue time that it is reading the last beat of a packet.
  // Without it the tail would only be seen a cycle after its registered RAM
  // read, and one extra read beyond the packet would already be in flight.
  logic [133:0]      mem [DEPTH];
  logic [DEPTH-1:0]  tail_flag;
  logic [133:0]      ram_q;

  logic [1:0]        w_state, w_state_nxt;
  logic [ADDR_W:0]   wr_ptr, wr_ptr_nxt, wr_commit;
  logic [ADDR_W:0]   base_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              commit_set, commit_pend;
  logic              start_head;
  logic [1:0]        drop_inc;

  logic [0:0]        r_state;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_start, rd_issue, rd_last, rd_vld;

  logic [ADDR_W:0]   pkt_cnt;

  logic              is_head, is_tail, full;

  assign is_head  = (data_in[133:132] == 2'b01);
  assign is_tail  = data_in[133];
  assign buf_used = wr_ptr - rd_ptr;
  assign full     = (buf_used == FULL_LVL);

  // ---------------------------------------------------------------- write
  always_comb begin
    w_state_nxt = w_state;
    wr_ptr_nxt  = wr_ptr;
    wr_en       = 1'b0;
    wr_addr     = wr_ptr[ADDR_W-1:0];
    drop_inc    = 2'd0;
    commit_set  = 1'b0;
    start_head  = 1'b0;
    base_ptr    = wr_ptr;

    if (data_in_valid) begin
      case (w_state)
        W_PKT: begin
          if (is_head) begin
            // Truncated packet: discard it, then start over from the last
            // committed position with this head.
            drop_inc   = 2'd1;
            base_ptr   = wr_commit;
            start_head = 1'b1;
          end else if (full) begin
            wr_ptr_nxt  = wr_commit;
            drop_inc    = 2'd1;
            w_state_nxt = is_tail ? W_IDLE : W_DROP;
          end else begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (is_tail) begin
              commit_set  = 1'b1;
              w_state_nxt = W_IDLE;
            end
          end
        end
        W_DROP: begin
          if (is_head) begin
            start_head = 1'b1;
          end else if (is_tail) begin
            w_state_nxt = W_IDLE;
          end
        end
        default: begin
          if (is_head) begin
            start_head = 1'b1;
          end
        end
      endcase

      if (start_head) begin
        if ((base_ptr - rd_ptr) == FULL_LVL) begin
          wr_ptr_nxt  = base_ptr;
          drop_inc    = drop_inc + 2'd1;
          w_state_nxt = W_DROP;
        end else begin
          wr_en       = 1'b1;
          wr_addr     = base_ptr[ADDR_W-1:0];
          wr_ptr_nxt  = base_ptr + PTR_ONE;
          w_state_nxt = W_PKT;
        end
      end
    end
  end

  // The commit is applied one cycle after the tail write. wr_ptr at that
  // point is exactly the post-tail pointer, even if a new head is being
  // written in the same cycle (that head only moves wr_ptr at the edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state      <= W_IDLE;
      wr_ptr       <= '0;
      wr_commit    <= '0;
      commit_pend  <= 1'b0;
      pkt_in_cnt   <= '0;
      pkt_drop_cnt <= '0;
      pkt_cnt      <= '0;
    end else begin
      w_state      <= w_state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      commit_pend  <= commit_set;
      pkt_drop_cnt <= pkt_drop_cnt + {30'd0, drop_inc};
      if (commit_pend) begin
        wr_commit  <= wr_ptr;
        pkt_in_cnt <= pkt_in_cnt + 32'd1;
      end
      case ({commit_pend, rd_start})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // ----------------------------------------------------------------- read
  assign rd_addr  = rd_ptr[ADDR_W-1:0];
  assign rd_start = (r_state == R_IDLE) && (pkt_cnt != '0);
  assign rd_issue = rd_start || (r_state == R_SEND);
  assign rd_last  = tail_flag[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr]       <= data_in;
      tail_flag[wr_addr] <= data_in[133];
    end
    if (rd_issue) begin
      ram_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= R_IDLE;
      rd_ptr         <= '0;
      rd_vld         <= 1'b0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
    end else begin
      if (rd_issue) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        r_state <= rd_last ? R_IDLE : R_SEND;
      end
      rd_vld         <= rd_issue;
      data_out_valid <= rd_vld;
      data_out       <= rd_vld ? ram_q : '0;
    end
  end

endmodule

// File: tb/tb_pkt_store_fwd.sv
// Scoreboard bench for pkt_store_fwd with a 16-beat buffer.
module tb_pkt_store_fwd;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_in_valid = 1'b0;
  logic [133:0]  data_in = '0;
  logic          data_out_valid;
  logic [133:0]  data_out;
  logic [31:0]   pkt_in_cnt;
  logic [31:0]   pkt_drop_cnt;
  logic [AW:0]   buf_used;

  pkt_store_fwd #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .pkt_in_cnt     (pkt_in_cnt),
    .pkt_drop_cnt   (pkt_drop_cnt),
    .buf_used       (buf_used)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = -1;
  bit prev_valid = 1'b0;
  bit in_pkt = 1'b0;
  logic [133:0] exp_q[$];
  logic [133:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output beat, checks bursts are
  // gap-free and that data_out is zero while idle.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt     = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (in_pkt) begin
        chk("burst_contiguous", {133'd0, data_out_valid}, 134'd1);
        if (!data_out_valid) in_pkt = 1'b0;
      end
      if (data_out_valid) begin
        if (!prev_valid) rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected no output", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("out_beat", data_out, mon_exp);
        end
        if (data_out[133:132] == 2'b01) in_pkt = 1'b1;
        else if (data_out[133]) in_pkt = 1'b0;
      end else begin
        chk("idle_data_zero", data_out, 134'd0);
      end
      prev_valid = data_out_valid;
    end
  end

  function automatic logic [133:0] mk(input logic [1:0] tag, input logic [3:0] vt, input int id);
    logic [31:0] w;
    w = 32'(id) ^ 32'h5A00_0000;
    return {tag, vt, w, ~w, w + 32'd7, 32'(id)};
  endfunction

  task automatic beat(input logic [133:0] b);
    data_in_valid = 1'b1;
    data_in       = b;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in       = '0;
  endtask

  task automatic send_pkt(input int n, input int id, input bit keep,
                          input logic [3:0] tail_vt, input logic [1:0] tail_tag);
    for (int i = 0; i < n; i++) begin
      logic [1:0]   t;
      logic [3:0]   v;
      logic [133:0] b;
      t = (i == 0) ? 2'b01 : ((i == n - 1) ? tail_tag : 2'b00);
      v = (i == n - 1) ? tail_vt : 4'hF;
      b = mk(t, v, id * 64 + i);
      if (keep) exp_q.push_back(b);
      beat(b);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk({"drain_", nm}, 134'(exp_q.size()), 134'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tail_cyc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {133'd0, data_out_valid}, 134'd0);
    chk("rst_data", data_out, 134'd0);
    chk("rst_in_cnt", 134'(pkt_in_cnt), 134'd0);
    chk("rst_drop_cnt", 134'(pkt_drop_cnt), 134'd0);
    chk("rst_buf_used", 134'(buf_used), 134'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single 4-beat packet, latency 3 cycles from tail
    send_pkt(4, 1, 1'b1, 4'h3, 2'b10);
    tail_cyc = cyc;
    chk("t1_buf_used_after_tail", 134'(buf_used), 134'd4);
    wait_drain("t1");
    chk("t1_latency", 134'(rise_cyc - tail_cyc), 134'd3);
    chk("t1_in_cnt", 134'(pkt_in_cnt), 134'd1);
    chk("t1_drop_cnt", 134'(pkt_drop_cnt), 134'd0);
    chk("t1_buf_used", 134'(buf_used), 134'd0);

    // 2: ten back-to-back 4-beat packets
    do_reset();
    for (int p = 0; p < 10; p++) send_pkt(4, 10 + p, 1'b1, 4'hF, 2'b10);
    wait_drain("t2");
    chk("t2_in_cnt", 134'(pkt_in_cnt), 134'd10);
    chk("t2_drop_cnt", 134'(pkt_drop_cnt), 134'd0);

    // 3: 20-beat packet overflows the 16-beat buffer; the next packet
    //    (ending with a 2'b11 tail) must still pass intact
    do_reset();
    send_pkt(4, 30, 1'b1, 4'hF, 2'b10);
    send_pkt(20, 31, 1'b0, 4'hF, 2'b10);
    send_pkt(4, 32, 1'b1, 4'h1, 2'b11);
    wait_drain("t3");
    chk("t3_in_cnt", 134'(pkt_in_cnt), 134'd2);
    chk("t3_drop_cnt", 134'(pkt_drop_cnt), 134'd1);
    chk("t3_buf_used", 134'(buf_used), 134'd0);

    // 4: head arriving mid-packet aborts the first packet
    do_reset();
    beat(mk(2'b01, 4'hF, 40 * 64));
    beat(mk(2'b00, 4'hF, 40 * 64 + 1));
    send_pkt(3, 41, 1'b1, 4'h7, 2'b10);
    wait_drain("t4");
    chk("t4_in_cnt", 134'(pkt_in_cnt), 134'd1);
    chk("t4_drop_cnt", 134'(pkt_drop_cnt), 134'd1);

    // 5: stray body beats without a head are ignored
    do_reset();
    for (int i = 0; i < 3; i++) beat(mk(2'b00, 4'hF, 50 * 64 + i));
    send_pkt(2, 51, 1'b1, 4'hF, 2'b10);
    wait_drain("t5");
    chk("t5_in_cnt", 134'(pkt_in_cnt), 134'd1);
    chk("t5_drop_cnt", 134'(pkt_drop_cnt), 134'd0);

    // 6: reset during the second output beat
    do_reset();
    send_pkt(4, 60, 1'b1, 4'hF, 2'b10);
    repeat (4) @(posedge clk);
    #6;
    chk("t6_second_beat_valid", {133'd0, data_out_valid}, 134'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {133'd0, data_out_valid}, 134'd0);
    chk("t6_rst_data", data_out, 134'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_buf_used", 134'(buf_used), 134'd0);
    chk("t6_in_cnt", 134'(pkt_in_cnt), 134'd0);
    repeat (20) @(posedge clk);
    #1;
    send_pkt(2, 61, 1'b1, 4'h1, 2'b10);
    wait_drain("t6");
    chk("t6_in_cnt_after", 134'(pkt_in_cnt), 134'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
